gyro_sample_scheduler: RTL and testbench
========================================

# gyro_sample_scheduler

Sequences raw gyro sampling for the orientation pipeline: generates a fixed-rate sample tick, runs a request/acknowledge read against the sensor reader, averages a startup bias per axis, and delivers bias-corrected, saturated rates with a valid strobe to the gyro integrator (`process_gyro_simple`). Sits between the sensor bus reader and the integrator. It owns calibration, overrun accounting and read-timeout recovery.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- SAMPLE_HZ, 1000, sample tick rate; TICK_DIV = CLK_HZ/SAMPLE_HZ (≥2)
- CAL_LOG2, 6, calibration averages 2^CAL_LOG2 samples
- TIMEOUT_CYCLES, 10000, max cycles rd_req_out waits for ack
- DEADBAND, 4, magnitude zeroed when GYRO_DEADBAND_EN defined
- clk_100mhz  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- recal_in  in  1  one-cycle pulse: restart calibration
- rd_req_out  out  1  read request, level, held until ack/timeout/recal
- rd_ack_in  in  1  one-cycle; raw_*_in valid this cycle
- raw_gx_in, raw_gy_in, raw_gz_in  in  16 each  signed raw rates
- gx_out, gy_out, gz_out  out  16 each  signed corrected rates
- rate_valid_out  out  1  one-cycle strobe, gx/gy/gz_out valid
- calibrated_out  out  1  high once bias is valid
- overrun_count_out  out  8  ticks dropped during a pending read, saturates at 255
- timeout_err_out  out  1  sticky, set on read timeout

## Operation
- Tick counter: 0..TICK_DIV-1, wraps; tick on TICK_DIV-1. Free-runs from reset, unaffected by recal.
- States: CAL_WAIT, CAL_READ, RUN_WAIT, RUN_READ. Reset state CAL_WAIT.
- *_WAIT + tick → matching *_READ, rd_req_out=1. Acks seen in *_WAIT are ignored.
- CAL_READ + ack: add raw samples to 16+CAL_LOG2-bit signed per-axis accumulators, then increment cal count. On the 2^CAL_LOG2-th ack: bias = acc >>> CAL_LOG2 (arithmetic), calibrated_out=1, go to RUN_WAIT. Otherwise return to CAL_WAIT.
- RUN_READ + ack: compute 17-bit diff = raw − bias per axis. Saturate to [−32768, 32767] and register into *_out. Pulse rate_valid_out. Go to RUN_WAIT.
- Tick in either *_READ state (including the ack cycle): tick dropped, overrun_count_out++ (saturating).
- Read timer counts cycles in *_READ. At TIMEOUT_CYCLES without ack: rd_req_out=0, timeout_err_out=1, return to matching *_WAIT. The sample is not counted toward calibration.
- recal_in (any state, highest priority): clear accumulators, cal count and bias. Set calibrated_out=0, rd_req_out=0, go to CAL_WAIT. An ack in the same cycle is discarded. *_out hold their last values. overrun_count_out and timeout_err_out are not cleared.
- Only rst_n_in clears timeout_err_out and overrun_count_out.

## Timing
- Reset (async assert, synchronous deassert handled upstream): all outputs 0, counters 0, state CAL_WAIT.
- rd_req_out rises the cycle after the tick cycle.
- rd_req_out falls the cycle after the ack, timeout or recal cycle.
- Latency: ack at cycle N → *_out updated and rate_valid_out=1 at cycle N+1, for exactly one cycle.
- calibrated_out rises at N+1 after the final calibration ack. No rate_valid_out is issued for calibration samples.
- At most one outstanding request; one rate_valid_out per accepted ack.

## Configuration
- GYRO_DEADBAND_EN defined: after saturation, any axis with |value| ≤ DEADBAND outputs 0.
- GYRO_DEADBAND_EN undefined: the saturated difference is output unchanged and the DEADBAND parameter is unused.

## Test plan
All scenarios use CLK_HZ=1000, SAMPLE_HZ=100 (TICK_DIV=10), CAL_LOG2=2, TIMEOUT_CYCLES=20, and ack 2 cycles after rd_req_out unless noted.
- Calibration: raw gx=100, gy=−50, gz=0 for 4 reads → calibrated_out=1 with no rate_valid_out. Next raw gx=356 → gx_out=256, gy_out=50 (raw 0), gz_out=0.
- Saturation: calibrate gx at −100, then raw gx=32700 → gx_out=32767. Calibrate at +100, raw −32700 → −32768.
- Overrun: in RUN, delay ack 15 cycles → overrun_count_out=1, exactly one rate_valid_out. Repeat 300 times → count holds at 255.
- Timeout: never ack → rd_req_out drops 20 cycles after rising, timeout_err_out=1 and stays 1. Next tick re-issues the request.
- Recal mid-read: recal_in pulsed in the same cycle as a RUN ack → no rate_valid_out, calibrated_out=0, state CAL_WAIT. Recalibration then completes after 4 more acks.
- Deadband (macro on, DEADBAND=4): corrected values 3, −4, 5 → outputs 0, 0, 5. With the macro off, the same inputs give 3, −4, 5.

Source files
------------

// File: rtl/gyro_sample_scheduler_if.sv
// Read handshake between the gyro sample scheduler (master) and the sensor bus reader (slave).
interface gyro_sample_scheduler_if;
  logic               rd_req_out;
  logic               rd_ack_in;
  logic signed [15:0] raw_gx_in;
  logic signed [15:0] raw_gy_in;
  logic signed [15:0] raw_gz_in;

  modport master (
    output rd_req_out,
    input  rd_ack_in, raw_gx_in, raw_gy_in, raw_gz_in
  );

  modport slave (
    input  rd_req_out,
    output rd_ack_in, raw_gx_in, raw_gy_in, raw_gz_in
  );
endinterface

// File: rtl/gyro_sample_scheduler.sv
// Fixed-rate gyro read sequencer: startup bias averaging, saturated bias correction,
// overrun counting and read-timeout recovery. Define GYRO_DEADBAND_EN to zero |rate| <= DEADBAND.
module gyro_sample_scheduler #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int CAL_LOG2       = 6,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int DEADBAND       = 4
) (
  input  logic                clk_100mhz,
  input  logic                rst_n_in,
  input  logic                recal_in,
  gyro_sample_scheduler_if.master rd_if,
  output logic signed [15:0]  gx_out,
  output logic signed [15:0]  gy_out,
  output logic signed [15:0]  gz_out,
  output logic                rate_valid_out,
  output logic                calibrated_out,
  output logic [7:0]          overrun_count_out,
  output logic                timeout_err_out
);
  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int ACC_W    = 16 + CAL_LOG2;
  localparam int CNT_W    = CAL_LOG2 + 1;

  typedef enum logic [1:0] {CAL_WAIT, CAL_READ, RUN_WAIT, RUN_READ} state_e;

  state_e                   state_q, state_d;
  logic [TICK_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [CNT_W-1:0]         cal_cnt_q, cal_cnt_d;
  logic [7:0]               overrun_q, overrun_d;
  logic                     rd_req_q, rd_req_d;
  logic                     rate_valid_q, rate_valid_d;
  logic                     calibrated_q, calibrated_d;
  logic                     timeout_err_q, timeout_err_d;
  logic signed [ACC_W-1:0]  acc_q [3];
  logic signed [ACC_W-1:0]  acc_d [3];
  logic signed [15:0]       bias_q [3];
  logic signed [15:0]       bias_d [3];
  logic signed [15:0]       out_q [3];
  logic signed [15:0]       out_d [3];
  logic signed [15:0]       raw [3];
  logic                     tick, in_read, ack;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)  return 16'sh7FFF;
    if (v < -17'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic logic signed [15:0] deadband(input logic signed [15:0] v);
    logic signed [15:0] lim;
    lim = 16'(DEADBAND);
    if ((v <= lim) && (v >= -lim)) return '0;
    return v;
  endfunction

  function automatic logic signed [15:0] correct(input logic signed [15:0] r,
                                                  input logic signed [15:0] b);
    logic signed [16:0] diff;
    logic signed [15:0] s;
    diff = $signed({r[15], r}) - $signed({b[15], b});
    s    = sat16(diff);
`ifdef GYRO_DEADBAND_EN
    s    = deadband(s);
`endif
    return s;
  endfunction

  assign raw[0]  = rd_if.raw_gx_in;
  assign raw[1]  = rd_if.raw_gy_in;
  assign raw[2]  = rd_if.raw_gz_in;
  assign ack     = rd_if.rd_ack_in;
  assign tick    = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign in_read = (state_q == CAL_READ) || (state_q == RUN_READ);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cal_cnt_d     = cal_cnt_q;
    overrun_d     = overrun_q;
    rd_req_d      = rd_req_q;
    rate_valid_d  = 1'b0;
    calibrated_d  = calibrated_q;
    timeout_err_d = timeout_err_q;
    acc_d         = acc_q;
    bias_d        = bias_q;
    out_d         = out_q;
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;

    // A tick landing while a read is still outstanding is dropped and counted.
    if (tick && in_read && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;

    if (recal_in) begin
      state_d      = CAL_WAIT;
      rd_req_d     = 1'b0;
      calibrated_d = 1'b0;
      cal_cnt_d    = '0;
      timer_d      = '0;
      for (int a = 0; a < 3; a++) begin
        acc_d[a]  = '0;
        bias_d[a] = '0;
      end
    end else begin
      case (state_q)
        CAL_WAIT, RUN_WAIT: begin
          if (tick) begin
            state_d  = (state_q == CAL_WAIT) ? CAL_READ : RUN_READ;
            rd_req_d = 1'b1;
            timer_d  = '0;
          end
        end
        CAL_READ, RUN_READ: begin
          if (ack) begin
            rd_req_d = 1'b0;
            if (state_q == CAL_READ) begin
              cal_cnt_d = cal_cnt_q + 1'b1;
              for (int a = 0; a < 3; a++) acc_d[a] = acc_q[a] + ACC_W'(raw[a]);
              if (cal_cnt_q == CNT_W'((1 << CAL_LOG2) - 1)) begin
                for (int a = 0; a < 3; a++) bias_d[a] = 16'(acc_d[a] >>> CAL_LOG2);
                calibrated_d = 1'b1;
                state_d      = RUN_WAIT;
              end else begin
                state_d = CAL_WAIT;
              end
            end else begin
              for (int a = 0; a < 3; a++) out_d[a] = correct(raw[a], bias_q[a]);
              rate_valid_d = 1'b1;
              state_d      = RUN_WAIT;
            end
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            rd_req_d      = 1'b0;
            timeout_err_d = 1'b1;
            state_d       = (state_q == CAL_READ) ? CAL_WAIT : RUN_WAIT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = CAL_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= CAL_WAIT;
      tick_cnt_q    <= '0;
      timer_q       <= '0;
      cal_cnt_q     <= '0;
      overrun_q     <= '0;
      rd_req_q      <= 1'b0;
      rate_valid_q  <= 1'b0;
      calibrated_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        acc_q[a]  <= '0;
        bias_q[a] <= '0;
        out_q[a]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      timer_q       <= timer_d;
      cal_cnt_q     <= cal_cnt_d;
      overrun_q     <= overrun_d;
      rd_req_q      <= rd_req_d;
      rate_valid_q  <= rate_valid_d;
      calibrated_q  <= calibrated_d;
      timeout_err_q <= timeout_err_d;
      acc_q         <= acc_d;
      bias_q        <= bias_d;
      out_q         <= out_d;
    end
  end

  assign rd_if.rd_req_out  = rd_req_q;
  assign gx_out            = out_q[0];
  assign gy_out            = out_q[1];
  assign gz_out            = out_q[2];
  assign rate_valid_out    = rate_valid_q;
  assign calibrated_out    = calibrated_q;
  assign overrun_count_out = overrun_q;
  assign timeout_err_out   = timeout_err_q;
endmodule

// File: tb/tb_gyro_sample_scheduler.sv
// Directed bench for gyro_sample_scheduler: calibration, saturation, deadband, overrun,
// timeout and recal-during-read, with hand-computed expectations.
module tb_gyro_sample_scheduler;
`ifdef GYRO_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic recal = 1'b0;
  logic signed [15:0] gx, gy, gz;
  logic rate_valid, calibrated, timeout_err, rd_req;
  logic [7:0] overrun;
  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int vld_ref = 0;
  int hi_cnt = 0;
  int nwait = 0;

  gyro_sample_scheduler_if rd_if();

  gyro_sample_scheduler #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .CAL_LOG2(2), .TIMEOUT_CYCLES(20), .DEADBAND(4)
  ) dut (
    .clk_100mhz(clk),
    .rst_n_in(rst_n),
    .recal_in(recal),
    .rd_if(rd_if),
    .gx_out(gx),
    .gy_out(gy),
    .gz_out(gz),
    .rate_valid_out(rate_valid),
    .calibrated_out(calibrated),
    .overrun_count_out(overrun),
    .timeout_err_out(timeout_err)
  );

  assign rd_req = rd_if.rd_req_out;

  always #5 clk = ~clk;

  always @(negedge clk) if (rate_valid === 1'b1) vld_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for a request, acks it dly cycles after it rises; returns in the cycle after the ack.
  task automatic do_read(input int dly, input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic signed [15:0] z, input bit with_recal);
    int n;
    n = 0;
    while (rd_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (rd_req !== 1'b1) begin
      chk("req_wait", rd_req, 1);
      return;
    end
    repeat (dly) step();
    rd_if.rd_ack_in = 1'b1;
    rd_if.raw_gx_in = x;
    rd_if.raw_gy_in = y;
    rd_if.raw_gz_in = z;
    recal = with_recal;
    step();
    rd_if.rd_ack_in = 1'b0;
    recal = 1'b0;
  endtask

  initial begin
    rd_if.rd_ack_in = 1'b0;
    rd_if.raw_gx_in = '0;
    rd_if.raw_gy_in = '0;
    rd_if.raw_gz_in = '0;
    repeat (3) step();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_valid", rate_valid, 0);
    chk("rst_calibrated", calibrated, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_gx", gx, 0);
    rst_n = 1'b1;

    // Calibration: bias = (100, -50, 0)
    do_read(2, 100, -50, 0, 0);
    chk("cal1_calibrated", calibrated, 0);
    chk("cal1_req_low", rd_req, 0);
    do_read(2, 100, -50, 0, 0);
    do_read(2, 100, -50, 0, 0);
    chk("cal3_calibrated", calibrated, 0);
    do_read(2, 100, -50, 0, 0);
    chk("cal4_calibrated", calibrated, 1);
    chk("cal4_valid", rate_valid, 0);
    step();
    chk("cal_no_valid", vld_cnt, 0);
    do_read(2, 356, 0, 0, 0);
    chk("run1_valid", rate_valid, 1);
    chk("run1_gx", gx, 256);
    chk("run1_gy", gy, 50);
    chk("run1_gz", gz, 0);
    chk("run1_req_low", rd_req, 0);
    step();
    chk("run1_valid_drop", rate_valid, 0);
    chk("run1_vld_cnt", vld_cnt, 1);

    // Ack while no request is pending must be ignored
    rd_if.rd_ack_in = 1'b1;
    step();
    rd_if.rd_ack_in = 1'b0;
    step();
    chk("stray_ack", vld_cnt, 1);

    // Saturation: bias = (-100, 100, 0)
    recal = 1'b1;
    step();
    recal = 1'b0;
    chk("recal_calibrated", calibrated, 0);
    repeat (4) do_read(2, -100, 100, 0, 0);
    chk("cal2_calibrated", calibrated, 1);
    do_read(2, 32700, -32700, 32767, 0);
    chk("sat_gx_pos", gx, 32767);
    chk("sat_gy_neg", gy, -32768);
    chk("sat_gz_edge", gz, 32767);
    do_read(2, 32667, -32668, -32768, 0);
    chk("edge_gx", gx, 32767);
    chk("edge_gy", gy, -32768);
    chk("edge_gz", gz, -32768);

    // Deadband region: corrected 3, -4, 5
    do_read(2, -97, 96, 5, 0);
    chk("db_gx", gx, DB_ON ? 0 : 3);
    chk("db_gy", gy, DB_ON ? 0 : -4);
    chk("db_gz", gz, 5);
    chk("db_overrun", overrun, 0);

    // Overrun: late ack lets one tick fall inside the read
    step();
    vld_ref = vld_cnt;
    do_read(15, 0, 0, 0, 0);
    chk("ovr1_count", overrun, 1);
    chk("ovr1_valid", rate_valid, 1);
    chk("ovr1_gx", gx, 100);
    for (int i = 1; i < 300; i++) do_read(15, 0, 0, 0, 0);
    chk("ovr_saturate", overrun, 255);
    step();
    chk("ovr_vld_cnt", vld_cnt - vld_ref, 300);

    // Timeout: no ack
    nwait = 0;
    while (rd_req !== 1'b1 && nwait < 40) begin
      step();
      nwait++;
    end
    chk("to_req_rise", rd_req, 1);
    hi_cnt = 0;
    while (rd_req === 1'b1 && hi_cnt < 40) begin
      hi_cnt++;
      step();
    end
    chk("to_req_high_cycles", hi_cnt, 20);
    chk("to_err_set", timeout_err, 1);
    chk("to_overrun_hold", overrun, 255);
    repeat (5) step();
    chk("to_err_sticky", timeout_err, 1);
    nwait = 0;
    while (rd_req !== 1'b1 && nwait < 20) begin
      step();
      nwait++;
    end
    chk("to_reissue", rd_req, 1);
    do_read(2, 1, 1, 50, 0);
    chk("to_next_gx", gx, 101);
    chk("to_next_gy", gy, -99);
    chk("to_next_gz", gz, 50);
    chk("to_err_after_read", timeout_err, 1);

    // Recal in the same cycle as a RUN ack
    step();
    vld_ref = vld_cnt;
    do_read(2, 500, 500, 500, 1);
    chk("rc_valid", rate_valid, 0);
    chk("rc_calibrated", calibrated, 0);
    chk("rc_req_low", rd_req, 0);
    chk("rc_gx_hold", gx, 101);
    chk("rc_gy_hold", gy, -99);
    chk("rc_gz_hold", gz, 50);
    do_read(2, 1, -1, 0, 0);
    do_read(2, 2, -2, 0, 0);
    do_read(2, 3, -3, 0, 0);
    chk("rc_cal3", calibrated, 0);
    do_read(2, 5, -5, 0, 0);
    chk("rc_cal4", calibrated, 1);
    step();
    chk("rc_no_valid", vld_cnt - vld_ref, 0);
    // bias = (11>>>2, -11>>>2, 0) = (2, -3, 0)
    do_read(2, 2, -3, 1000, 0);
    chk("rc_run_valid", rate_valid, 1);
    chk("rc_run_gx", gx, 0);
    chk("rc_run_gy", gy, 0);
    chk("rc_run_gz", gz, 1000);
    step();
    chk("rc_valid_drop", rate_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
